// File: rtl/sensor_pkg.sv
// Shared types and widths for the sensor sequencer: FSM state encoding,
// pixel-index width and integration-time width.
package sensor_pkg;

  localparam int PIX_IDX_W  = 11;
  localparam int INT_TIME_W = 21;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INTEG    = 3'd1,
    VDLY     = 3'd2,
    READ     = 3'd3,
    WAIT_EOC = 3'd4,
    DONE     = 3'd5
  } seq_state_t;

endpackage

// File: rtl/eoc_sync_edge.sv
// Brings the asynchronous EOC line into the FPGA_CLK domain and emits a
// one-cycle registered pulse on its rising edge (3 cycles after EOC rises).
module eoc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic eoc_async,
  output logic eoc_rise
);

  logic sync1_q, sync2_q, prev_q;
  logic rise_d, rise_q;

  always_comb begin
    rise_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= eoc_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= rise_d;
    end
  end

  assign eoc_rise = rise_q;

endmodule

// File: rtl/sensor_seq_ctrl.sv
// Linear image sensor sequencer: free-running SENSOR_CLK, integration, video
// delay, pixel readout and EOC handshake. `define SENSOR_EOC_TMO_EN adds the EOC timeout.
module sensor_seq_ctrl
  import sensor_pkg::*;
#(
  parameter int DIV     = 8,
  parameter int PIXELS  = 1024,
  parameter int VID_DLY = 14,
  parameter int EOC_TMO = 4096
) (
  input  logic                  FPGA_CLK,
  input  logic                  FPGA_RST,
  input  logic                  START,
  input  logic                  CONT,
  input  logic [INT_TIME_W-1:0] INT_TIME,
  input  logic                  EOC,
  output logic                  SENSOR_CLK,
  output logic                  ST,
  output logic                  PIX_VALID,
  output logic [PIX_IDX_W-1:0]  PIX_IDX,
  output logic                  BUSY,
  output logic                  FRAME_DONE,
  output logic                  EOC_EARLY,
  output logic                  EOC_TMO_ERR
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DLY_W = (VID_DLY > 1) ? $clog2(VID_DLY) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DLY_W-1:0]     DLY_LAST = DLY_W'(VID_DLY - 1);
  localparam logic [PIX_IDX_W-1:0] PIX_LAST = PIX_IDX_W'(PIXELS - 1);

  if (DIV < 1 || PIXELS < 1 || PIXELS > (1 << PIX_IDX_W) || VID_DLY < 1 || EOC_TMO < 1) begin : g_bad_cfg
    $error("sensor_seq_ctrl: illegal parameter combination");
  end

  logic                  eoc_rise;
  logic                  tick;
  logic [INT_TIME_W-1:0] int_time_eff;
  logic [PIX_IDX_W-1:0]  pix_next;

  seq_state_t            state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  st_q, st_d;
  logic                  pix_valid_q, pix_valid_d;
  logic [PIX_IDX_W-1:0]  pix_idx_q, pix_idx_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  eoc_early_q, eoc_early_d;
  logic                  start_pend_q, start_pend_d;
  logic [INT_TIME_W-1:0] int_cnt_q, int_cnt_d;
  logic [DLY_W-1:0]      dly_cnt_q, dly_cnt_d;
`ifdef SENSOR_EOC_TMO_EN
  localparam int TMO_W = (EOC_TMO > 1) ? $clog2(EOC_TMO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(EOC_TMO - 1);
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  tmo_err_q, tmo_err_d;
`endif

  eoc_sync_edge u_eoc_sync (
    .clk       (FPGA_CLK),
    .rst_n     (FPGA_RST),
    .eoc_async (EOC),
    .eoc_rise  (eoc_rise)
  );

  always_comb begin
    div_cnt_d    = div_cnt_q + 1'b1;
    sclk_d       = sclk_q;
    tick         = 1'b0;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      sclk_d    = ~sclk_q;
      tick      = ~sclk_q;
    end

    // A zero integration request would never raise ST; treat it as one period.
    int_time_eff = (INT_TIME == '0) ? INT_TIME_W'(1) : INT_TIME;
    pix_next     = pix_idx_q + 1'b1;

    state_d      = state_q;
    st_d         = st_q;
    pix_valid_d  = 1'b0;
    pix_idx_d    = pix_idx_q;
    frame_done_d = 1'b0;
    eoc_early_d  = eoc_early_q;
    start_pend_d = start_pend_q;
    int_cnt_d    = int_cnt_q;
    dly_cnt_d    = dly_cnt_q;
`ifdef SENSOR_EOC_TMO_EN
    tmo_cnt_d    = tmo_cnt_q;
    tmo_err_d    = tmo_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (START) begin
          start_pend_d = 1'b1;
          eoc_early_d  = 1'b0;
`ifdef SENSOR_EOC_TMO_EN
          tmo_err_d    = 1'b0;
`endif
        end
        if (tick && (start_pend_q || START || CONT)) begin
          start_pend_d = 1'b0;
          state_d      = INTEG;
          st_d         = 1'b1;
          int_cnt_d    = int_time_eff;
          pix_idx_d    = '0;
        end
      end
      INTEG: begin
        if (tick) begin
          if (int_cnt_q <= INT_TIME_W'(1)) begin
            st_d      = 1'b0;
            state_d   = VDLY;
            dly_cnt_d = '0;
          end else begin
            int_cnt_d = int_cnt_q - 1'b1;
          end
        end
      end
      VDLY: begin
        if (tick) begin
          if (dly_cnt_q == DLY_LAST) begin
            pix_valid_d = 1'b1;
            pix_idx_d   = '0;
            state_d     = (PIXELS == 1) ? WAIT_EOC : READ;
`ifdef SENSOR_EOC_TMO_EN
            tmo_cnt_d   = '0;
`endif
          end else begin
            dly_cnt_d = dly_cnt_q + 1'b1;
          end
        end
      end
      READ: begin
        // An early EOC wins over a coincident tick so no strobe follows it.
        if (eoc_rise) begin
          eoc_early_d  = 1'b1;
          frame_done_d = 1'b1;
          state_d      = DONE;
        end else if (tick) begin
          pix_valid_d = 1'b1;
          pix_idx_d   = pix_next;
          if (pix_next == PIX_LAST) begin
            state_d = WAIT_EOC;
`ifdef SENSOR_EOC_TMO_EN
            tmo_cnt_d = '0;
`endif
          end
        end
      end
      WAIT_EOC: begin
        if (eoc_rise) begin
          frame_done_d = 1'b1;
          state_d      = DONE;
        end
`ifdef SENSOR_EOC_TMO_EN
        else if (tick) begin
          if (tmo_cnt_q == TMO_LAST) begin
            tmo_err_d    = 1'b1;
            frame_done_d = 1'b1;
            state_d      = DONE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
`endif
      end
      DONE: begin
        if (tick) begin
          if (CONT) begin
            state_d   = INTEG;
            st_d      = 1'b1;
            int_cnt_d = int_time_eff;
            pix_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      sclk_q       <= 1'b0;
      st_q         <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_idx_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      eoc_early_q  <= 1'b0;
      start_pend_q <= 1'b0;
      int_cnt_q    <= '0;
      dly_cnt_q    <= '0;
`ifdef SENSOR_EOC_TMO_EN
      tmo_cnt_q    <= '0;
      tmo_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      sclk_q       <= sclk_d;
      st_q         <= st_d;
      pix_valid_q  <= pix_valid_d;
      pix_idx_q    <= pix_idx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      eoc_early_q  <= eoc_early_d;
      start_pend_q <= start_pend_d;
      int_cnt_q    <= int_cnt_d;
      dly_cnt_q    <= dly_cnt_d;
`ifdef SENSOR_EOC_TMO_EN
      tmo_cnt_q    <= tmo_cnt_d;
      tmo_err_q    <= tmo_err_d;
`endif
    end
  end

  assign SENSOR_CLK = sclk_q;
  assign ST         = st_q;
  assign PIX_VALID  = pix_valid_q;
  assign PIX_IDX    = pix_idx_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = frame_done_q;
  assign EOC_EARLY  = eoc_early_q;
`ifdef SENSOR_EOC_TMO_EN
  assign EOC_TMO_ERR = tmo_err_q;
`else
  assign EOC_TMO_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_seq_ctrl.sv
// Directed bench for sensor_seq_ctrl: reset, full frame timing, early EOC,
// continuous mode, mid-frame reset and the WAIT_EOC timeout / stall behaviour.
module tb_sensor_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        eoc = 1'b0;
  logic [20:0] int_time = 21'd0;
  logic        sclk, st, pix_valid, busy, frame_done, eoc_early, eoc_tmo_err;
  logic [10:0] pix_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sensor_seq_ctrl #(
    .DIV     (8),
    .PIXELS  (1024),
    .VID_DLY (14),
    .EOC_TMO (64)
  ) dut (
    .FPGA_CLK    (clk),
    .FPGA_RST    (rst_n),
    .START       (start),
    .CONT        (cont),
    .INT_TIME    (int_time),
    .EOC         (eoc),
    .SENSOR_CLK  (sclk),
    .ST          (st),
    .PIX_VALID   (pix_valid),
    .PIX_IDX     (pix_idx),
    .BUSY        (busy),
    .FRAME_DONE  (frame_done),
    .EOC_EARLY   (eoc_early),
    .EOC_TMO_ERR (eoc_tmo_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Collects strobes from the current sample onward until max_pix are seen.
  task automatic collect_pixels(input int max_pix, output int n, output int bad, output int fd);
    int guard;
    guard = 0; n = 0; bad = 0; fd = 0;
    while (guard < 40000) begin
      if (pix_valid) begin
        if (pix_idx !== n[10:0]) bad++;
        n++;
      end
      if (frame_done) fd++;
      if (n >= max_pix) break;
      step();
      guard++;
    end
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    logic        prev;
    int          rises, busy_seen;
    repeat (3) step();
    outs = {sclk, st, pix_valid, pix_idx, busy, frame_done, eoc_early, eoc_tmo_err};
    checks++;
    if (outs !== 18'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", outs);
    end
    rst_n = 1'b1;
    prev = sclk; rises = 0; busy_seen = 0;
    repeat (64) begin
      step();
      if (sclk && !prev) rises++;
      prev = sclk;
      if (busy) busy_seen++;
    end
    checks++;
    if (rises !== 4) begin
      errors++; $display("FAIL sclk_rises got %0d want 4", rises);
    end
    checks++;
    if (busy_seen !== 0) begin
      errors++; $display("FAIL idle_busy got %0d busy cycles want 0", busy_seen);
    end
  endtask

  task automatic test_frame();
    int guard, ncyc, n, bad, fd, extra;
    int_time = 21'd10;
    start = 1'b1; step(); start = 1'b0;
    guard = 0;
    while (!st && guard < 100) begin step(); guard++; end
    checks++;
    if (st !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL frame_st_rise st=%b busy=%b want 1 1", st, busy);
    end
    ncyc = 0;
    while (st && ncyc < 1000) begin
      ncyc++;
      start = (ncyc == 50);
      step();
    end
    start = 1'b0;
    checks++;
    if (ncyc !== 160) begin
      errors++; $display("FAIL st_high got %0d want 160", ncyc);
    end
    ncyc = 0;
    while (!pix_valid && ncyc < 1000) begin step(); ncyc++; end
    checks++;
    if (ncyc !== 224 || pix_idx !== 11'd0) begin
      errors++; $display("FAIL vid_delay got %0d cycles idx %0d want 224 idx 0", ncyc, pix_idx);
    end
    collect_pixels(1024, n, bad, fd);
    checks++;
    if (n !== 1024 || bad !== 0) begin
      errors++; $display("FAIL frame_pixels got %0d strobes %0d bad idx want 1024 0", n, bad);
    end
    extra = 0;
    repeat (50 * 16) begin
      step();
      if (pix_valid) extra++;
      if (frame_done) fd++;
    end
    checks++;
    if (extra !== 0 || fd !== 0) begin
      errors++; $display("FAIL wait_eoc_quiet got %0d strobes %0d done want 0 0", extra, fd);
    end
    eoc = 1'b1;
    ncyc = 0;
    while (!frame_done && ncyc < 50) begin step(); ncyc++; end
    checks++;
    if (frame_done !== 1'b1 || ncyc !== 4) begin
      errors++; $display("FAIL eoc_latency got done=%b after %0d want done=1 after 4", frame_done, ncyc);
    end
    step();
    eoc = 1'b0;
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL done_pulse got %b want 0", frame_done);
    end
    guard = 0;
    while (busy && guard < 40) begin step(); guard++; end
    checks++;
    if (busy !== 1'b0 || eoc_early !== 1'b0) begin
      errors++; $display("FAIL frame_end busy=%b early=%b want 0 0", busy, eoc_early);
    end
    ncyc = 0;
    repeat (64) begin step(); if (busy) ncyc++; end
    checks++;
    if (ncyc !== 0) begin
      errors++; $display("FAIL start_not_queued got %0d busy cycles want 0", ncyc);
    end
  endtask

  task automatic test_eoc_early();
    int guard, ncyc, extra;
    int_time = 21'd5;
    start = 1'b1; step(); start = 1'b0;
    guard = 0;
    while (!(pix_valid && pix_idx == 11'd500) && guard < 20000) begin step(); guard++; end
    checks++;
    if (pix_valid !== 1'b1 || pix_idx !== 11'd500) begin
      errors++; $display("FAIL reach_pix500 got valid=%b idx=%0d want 1 500", pix_valid, pix_idx);
    end
    eoc = 1'b1;
    ncyc = 0; extra = 0;
    while (!frame_done && ncyc < 50) begin
      step(); ncyc++;
      if (pix_valid) extra++;
      if (ncyc == 2) eoc = 1'b0;
    end
    eoc = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || eoc_early !== 1'b1) begin
      errors++; $display("FAIL early_done done=%b early=%b want 1 1", frame_done, eoc_early);
    end
    checks++;
    if (extra !== 0 || pix_idx !== 11'd500) begin
      errors++; $display("FAIL early_stop got %0d strobes last idx %0d want 0 500", extra, pix_idx);
    end
    guard = 0;
    while (busy && guard < 40) begin step(); guard++; end
    checks++;
    if (busy !== 1'b0 || eoc_early !== 1'b1) begin
      errors++; $display("FAIL early_idle busy=%b early=%b want 0 1", busy, eoc_early);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] outs;
    int guard, ncyc, n, bad, fd, drops;
    cont = 1'b1; start = 1'b1; int_time = 21'd0;
    step(); start = 1'b0;
    checks++;
    if (eoc_early !== 1'b0) begin
      errors++; $display("FAIL flag_clear got %b want 0", eoc_early);
    end
    guard = 0;
    while (!st && guard < 50) begin step(); guard++; end
    ncyc = 0;
    while (st && ncyc < 1000) begin step(); ncyc++; end
    checks++;
    if (ncyc !== 16) begin
      errors++; $display("FAIL cont_st1 got %0d want 16", ncyc);
    end
    start = 1'b1; step(); start = 1'b0;
    guard = 0;
    while (!pix_valid && guard < 1000) begin step(); guard++; end
    collect_pixels(1024, n, bad, fd);
    checks++;
    if (n !== 1024 || bad !== 0 || fd !== 0) begin
      errors++; $display("FAIL cont_pixels got %0d strobes %0d bad %0d done want 1024 0 0", n, bad, fd);
    end
    repeat (10 * 16) step();
    eoc = 1'b1;
    guard = 0;
    while (!frame_done && guard < 50) begin step(); guard++; end
    eoc = 1'b0;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL cont_done got %b want 1", frame_done);
    end
    ncyc = 0; drops = 0;
    while (!st && ncyc < 40) begin
      step(); ncyc++;
      if (!busy) drops++;
    end
    checks++;
    if (st !== 1'b1 || ncyc > 16 || drops !== 0) begin
      errors++; $display("FAIL cont_restart st=%b after %0d idle %0d want st=1 within 16 idle 0", st, ncyc, drops);
    end
    cont = 1'b0;
    ncyc = 0;
    while (st && ncyc < 1000) begin step(); ncyc++; end
    checks++;
    if (ncyc !== 16) begin
      errors++; $display("FAIL cont_st2 got %0d want 16", ncyc);
    end
    guard = 0;
    while (!(pix_valid && pix_idx == 11'd300) && guard < 20000) begin step(); guard++; end
    checks++;
    if (pix_valid !== 1'b1 || pix_idx !== 11'd300) begin
      errors++; $display("FAIL reach_pix300 got valid=%b idx=%0d want 1 300", pix_valid, pix_idx);
    end
    rst_n = 1'b0;
    #1;
    outs = {sclk, st, pix_valid, pix_idx, busy, frame_done, eoc_early, eoc_tmo_err};
    checks++;
    if (outs !== 18'd0) begin
      errors++; $display("FAIL async_reset got %h want 0", outs);
    end
    fd = 0;
    repeat (3) begin
      step();
      if ({sclk, st, pix_valid, pix_idx, busy, frame_done, eoc_early, eoc_tmo_err} !== 18'd0) fd++;
    end
    rst_n = 1'b1;
    repeat (8) begin step(); if (frame_done || busy) fd++; end
    checks++;
    if (fd !== 0) begin
      errors++; $display("FAIL reset_hold got %0d bad cycles want 0", fd);
    end
  endtask

  task automatic test_after_reset();
    int guard, ncyc, n, bad, fd;
    int_time = 21'd3;
    start = 1'b1; step(); start = 1'b0;
    guard = 0;
    while (!st && guard < 50) begin step(); guard++; end
    ncyc = 0;
    while (st && ncyc < 1000) begin step(); ncyc++; end
    checks++;
    if (ncyc !== 48) begin
      errors++; $display("FAIL post_reset_st got %0d want 48", ncyc);
    end
    guard = 0;
    while (!pix_valid && guard < 1000) begin step(); guard++; end
    collect_pixels(1024, n, bad, fd);
    checks++;
    if (n !== 1024 || bad !== 0 || fd !== 0) begin
      errors++; $display("FAIL post_reset_pixels got %0d strobes %0d bad %0d done want 1024 0 0", n, bad, fd);
    end
`ifdef SENSOR_EOC_TMO_EN
    ncyc = 0;
    while (!eoc_tmo_err && ncyc < 2000) begin step(); ncyc++; end
    checks++;
    if (eoc_tmo_err !== 1'b1 || ncyc !== 1024 || frame_done !== 1'b1) begin
      errors++; $display("FAIL eoc_timeout err=%b after %0d done=%b want 1 after 1024 done=1", eoc_tmo_err, ncyc, frame_done);
    end
    guard = 0;
    while (busy && guard < 40) begin step(); guard++; end
    checks++;
    if (busy !== 1'b0 || eoc_tmo_err !== 1'b1) begin
      errors++; $display("FAIL timeout_idle busy=%b err=%b want 0 1", busy, eoc_tmo_err);
    end
`else
    bad = 0;
    repeat (100 * 16) begin
      step();
      if (!busy || frame_done || eoc_tmo_err) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL eoc_stall got %0d bad cycles want 0", bad);
    end
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
`endif
  endtask

  initial begin
    test_reset();
    test_frame();
    test_eoc_early();
    test_back_to_back();
    test_after_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
